// File: rtl/inert_pkg.sv
// Shared state encoding and SPI command words for the inertial sensor sequencer.
package inert_pkg;

  localparam int unsigned CMD_W   = 16;
  localparam int unsigned TIMER_W = 20;
  localparam int unsigned POR_W   = 16;

  typedef enum logic [2:0] {
    POR_WAIT,
    CFG1,
    CFG2,
    WAIT_INT,
    RD_PL,
    RD_PH,
    RD_AL,
    RD_AH
  } state_t;

  // SPI master command word: {R/Wn, register address, write data}
  typedef struct packed {
    logic       rd_wn;
    logic [6:0] addr;
    logic [7:0] data;
  } spi_cmd_t;

  localparam spi_cmd_t CMD_CFG1  = '{rd_wn: 1'b0, addr: 7'h0D, data: 8'h02};
  localparam spi_cmd_t CMD_CFG2  = '{rd_wn: 1'b0, addr: 7'h11, data: 8'h50};
  localparam spi_cmd_t CMD_RD_PL = '{rd_wn: 1'b1, addr: 7'h22, data: 8'h00};
  localparam spi_cmd_t CMD_RD_PH = '{rd_wn: 1'b1, addr: 7'h23, data: 8'h00};
  localparam spi_cmd_t CMD_RD_AL = '{rd_wn: 1'b1, addr: 7'h2C, data: 8'h00};
  localparam spi_cmd_t CMD_RD_AH = '{rd_wn: 1'b1, addr: 7'h2D, data: 8'h00};

endpackage

// File: rtl/inert_timer.sv
// 20-bit wait/watchdog counter with clear, enable and a terminal compare against a supplied limit.
module inert_timer
  import inert_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic               por_mode,
  input  logic [TIMER_W-1:0] limit,
  output logic               term_c
);

  logic [TIMER_W-1:0] cnt;
  logic [TIMER_W-1:0] cmp_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TIMER_W'(1);
    end
  end

  // The power-up wait compares only the low 16 bits
  assign cmp_c  = por_mode ? TIMER_W'(cnt[POR_W-1:0]) : cnt;
  assign term_c = (cmp_c == limit);

endmodule

// File: rtl/inert_seq_ctrl.sv
// Sequencer for the inertial sensor: power-up wait, register config, then INT-driven
// pitch-rate / AZ reads through the SPI master, with an INT watchdog.
module inert_seq_ctrl
  import inert_pkg::*;
#(
  parameter logic [15:0] INIT_WAIT   = 16'hFFFF,
  parameter logic [19:0] INT_TIMEOUT = 20'hFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              INT,
  input  logic              done,
  input  logic [CMD_W-1:0]  rd_data,
  output logic              wrt,
  output logic [CMD_W-1:0]  cmd,
  output logic [15:0]       ptch_rt,
  output logic [15:0]       AZ,
  output logic              vld,
  output logic              sensor_err
);

  state_t             state;
  spi_cmd_t           cmd_q;
  logic               int_ff1;
  logic               int_s;
  logic [7:0]         lo_p;
  logic [7:0]         hi_p;
  logic [7:0]         lo_a;
  logic               done_ok_c;
  logic               por_c;
  logic               tmr_clr_c;
  logic               tmr_en_c;
  logic               tmr_term_c;
  logic [TIMER_W-1:0] tmr_limit_c;
  logic               unused_rd_hi;

  assign cmd          = cmd_q;
  assign unused_rd_hi = ^rd_data[CMD_W-1:8];

  // A done coincident with the start pulse cannot belong to this transaction
  assign done_ok_c = done & ~wrt;

  // Timer only runs in the two waiting states, so any state change clears it
  assign por_c       = (state == POR_WAIT);
  assign tmr_clr_c   = ~(por_c | (state == WAIT_INT));
  assign tmr_en_c    = por_c | ~int_s;
  assign tmr_limit_c = por_c ? TIMER_W'(INIT_WAIT - 16'd1) : (INT_TIMEOUT - TIMER_W'(1));

  inert_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr_c),
    .en       (tmr_en_c),
    .por_mode (por_c),
    .limit    (tmr_limit_c),
    .term_c   (tmr_term_c)
  );

  // Two-flop synchronizer for the asynchronous sensor interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1 <= 1'b0;
      int_s   <= 1'b0;
    end else begin
      int_ff1 <= INT;
      int_s   <= int_ff1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= POR_WAIT;
      wrt        <= 1'b0;
      cmd_q      <= '0;
      ptch_rt    <= '0;
      AZ         <= '0;
      vld        <= 1'b0;
      sensor_err <= 1'b0;
      lo_p       <= '0;
      hi_p       <= '0;
      lo_a       <= '0;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      case (state)
        POR_WAIT: if (tmr_term_c) begin
          state <= CFG1;
          wrt   <= 1'b1;
          cmd_q <= CMD_CFG1;
        end
        CFG1: if (done_ok_c) begin
          state <= CFG2;
          wrt   <= 1'b1;
          cmd_q <= CMD_CFG2;
        end
        CFG2: if (done_ok_c) begin
          state <= WAIT_INT;
        end
        WAIT_INT: begin
          if (int_s) begin
            state <= RD_PL;
            wrt   <= 1'b1;
            cmd_q <= CMD_RD_PL;
          end else if (tmr_term_c) begin
            sensor_err <= 1'b1;
            state      <= CFG1;
            wrt        <= 1'b1;
            cmd_q      <= CMD_CFG1;
          end
        end
        RD_PL: if (done_ok_c) begin
          lo_p  <= rd_data[7:0];
          state <= RD_PH;
          wrt   <= 1'b1;
          cmd_q <= CMD_RD_PH;
        end
        RD_PH: if (done_ok_c) begin
          hi_p  <= rd_data[7:0];
          state <= RD_AL;
          wrt   <= 1'b1;
          cmd_q <= CMD_RD_AL;
        end
        RD_AL: if (done_ok_c) begin
          lo_a  <= rd_data[7:0];
          state <= RD_AH;
          wrt   <= 1'b1;
          cmd_q <= CMD_RD_AH;
        end
        RD_AH: if (done_ok_c) begin
          // Both words publish on the same edge as vld
          ptch_rt <= {hi_p, lo_p};
          AZ      <= {rd_data[7:0], lo_a};
          vld     <= 1'b1;
          state   <= WAIT_INT;
        end
        default: state <= POR_WAIT;
      endcase
    end
  end

endmodule

// File: doc/inert_seq_ctrl.md
Name: inert_seq_ctrl

Overview:
- Master-side sequencer for the inertial sensor on the SPI bus. It sits between the balance-control datapath and the 16-bit SPI master, which is a separate block.
- After power-up it waits, then configures the sensor: register 0x0D=0x02 and register 0x11=0x50. This enables the sensor's measurement cycle.
- It then loops forever: wait for the sensor INT, read pitch rate (0x22/0x23) and AZ (0x2C/0x2D), and present both as 16-bit words with a one-cycle valid strobe.
- If INT stops arriving, a watchdog flags an error and the block reconfigures the sensor.

Parameters:
- INIT_WAIT, 16'hFFFF, clk cycles to wait after reset before the first SPI transaction (sensor POR settle).
- INT_TIMEOUT, 20'hFFFFF, clk cycles allowed in WAIT_INT before declaring a sensor fault.

Ports:
- clk  input  1  system clock (50MHz).
- rst_n  input  1  asynchronous active-low reset (already synchronized upstream).
- INT  input  1  raw sensor interrupt, asynchronous to clk.
- done  input  1  SPI master: one-cycle pulse at transaction completion.
- rd_data  input  16  SPI master: word shifted in; bits [7:0] hold the register byte.
- wrt  output  1  SPI master: one-cycle start pulse.
- cmd  output  16  SPI master command {R/Wn, addr[6:0], data[7:0]}, held stable from wrt until done.
- ptch_rt  output  16  signed pitch rate {hi,lo}.
- AZ  output  16  signed Z acceleration {hi,lo}.
- vld  output  1  one-cycle pulse when ptch_rt/AZ are updated.
- sensor_err  output  1  sticky; set on INT timeout.

Behaviour:
- Reset values: wrt=0, cmd=16'h0000, ptch_rt=16'h0000, AZ=16'h0000, vld=0, sensor_err=0, state=POR_WAIT, INT synchronizer flops=0, timer=0.
- INT path: two-flop synchronizer, INT_s = second flop. WAIT_INT samples INT_s only (2-cycle latency).
- Each command state pulses wrt for exactly 1 cycle on entry, drives cmd, then waits for done.
  - done is honoured only in the matching wait state; done seen in any other state is ignored.
  - wrt is never reissued before done.
  - done arriving in the same cycle as wrt is ignored; the SPI master cannot complete in 0 cycles.
- States and transitions:
  - POR_WAIT: timer counts to INIT_WAIT-1, then go to CFG1.
  - CFG1: cmd=16'h0D02; on done go to CFG2.
  - CFG2: cmd=16'h1150; on done go to WAIT_INT, clearing the timer.
  - WAIT_INT: if INT_s, go to RD_PL and clear the timer. Else if timer==INT_TIMEOUT-1, set sensor_err and go to CFG1. Else increment the timer.
  - RD_PL: cmd=16'hA200; on done, lo_p<=rd_data[7:0], go to RD_PH. Reading 0x22 clears INT in the sensor.
  - RD_PH: cmd=16'hA300; on done, hi_p<=rd_data[7:0], go to RD_AL.
  - RD_AL: cmd=16'hAC00; on done, lo_a<=rd_data[7:0], go to RD_AH.
  - RD_AH: cmd=16'hAD00; on done, update both outputs in the same edge, pulse vld for 1 cycle, go to WAIT_INT.
    - ptch_rt<={hi_p,lo_p}.
    - AZ<={rd_data[7:0],lo_a}.
- Output atomicity: ptch_rt and AZ change only together, coincident with vld. Partial bytes live in internal holding regs.
- Latency: vld rises 1 clk after the done of the RD_AH transaction.
- Back-to-back INT: INT still high on return to WAIT_INT starts a new read immediately. Allow for the 2-cycle synchronizer lag after the 0x22 read clears INT.
- sensor_err clears only on reset. After a timeout the block keeps operating normally.
- Reset mid-transaction: all state resets immediately and the SPI transaction is abandoned. The SPI master is reset by the same rst_n.
- Timer: 20-bit, shared between POR_WAIT and WAIT_INT, cleared on every state change. The POR comparison uses the timer's low 16 bits zero-extended.

Decomposition:
- Shared package inert_pkg:
  - state_t enum {POR_WAIT,CFG1,CFG2,WAIT_INT,RD_PL,RD_PH,RD_AL,RD_AH}.
  - Command constants: CMD_CFG1=16'h0D02, CMD_CFG2=16'h1150, CMD_RD_PL=16'hA200, CMD_RD_PH=16'hA300, CMD_RD_AL=16'hAC00, CMD_RD_AH=16'hAD00.
- One sub-module: inert_timer. It is a 20-bit counter with clr/en inputs and a terminal-compare output against a supplied limit.
- The synchronizer, FSM and holding registers stay in inert_seq_ctrl.

Test Plan:
- Power-up: reset, INIT_WAIT=16 → no wrt for 16 cycles. Then wrt with cmd=16'h0D02, then, after done, wrt with cmd=16'h1150.
- Read cycle: after config, raise INT. The SPI model returns bytes 0xC2,0x03,0x80,0xFE → exactly four wrt with cmds A200,A300,AC00,AD00. Then vld=1 for 1 cycle with ptch_rt=16'h03C2 and AZ=16'hFE80.
- Atomicity: sample ptch_rt/AZ every cycle during the reads → both hold their previous values until the vld edge.
- Timeout: INT_TIMEOUT=32, INT held low → sensor_err=1 at cycle 32 of WAIT_INT and cmd=16'h0D02 reissued. sensor_err stays 1 through a later good read.
- Stray done: pulse done during WAIT_INT and POR_WAIT → no state change and no wrt.
- Reset mid-read: assert rst_n=0 during RD_AL → wrt=0, vld=0, ptch_rt=0, AZ=0, sensor_err=0 immediately. After release the full POR_WAIT/CFG sequence repeats.
